aes_fault_ctrl: RTL

Sequencing and fault-handling controller for a triple-redundant AES datapath. It accepts one plaintext/key pair over a valid/ready handshake and holds it stable on the engine inputs for a fixed number of cycles. It then word-votes the three engine outputs, retries the block on a total disagreement, and returns the voted ciphertext over a second valid/ready handshake. Three `aes` instances sit beside it at the top level; this block instantiates none of them.

---
 rtl/aes_ctrl_pkg.sv | 14 +
 rtl/aes_vote3.sv | 29 ++
 rtl/aes_fault_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the triple-redundant AES sequencing controller.
package aes_ctrl_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    CHECK = 3'd2,
    OUT   = 3'd3,
    LOCK  = 3'd4
  } state_t;

endpackage

// File: rtl/aes_vote3.sv
// Word-level 2-of-3 voter over the three engine outputs.
module aes_vote3
  import aes_ctrl_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] c1,
  input  logic [AES_BLOCK_W-1:0] c2,
  input  logic [AES_BLOCK_W-1:0] c3,
  output logic [AES_BLOCK_W-1:0] vote_word,
  output logic                   all_agree,
  output logic                   two_agree,
  output logic                   no_agree
);

  logic eq12;
  logic eq13;
  logic eq23;

  assign eq12 = (c1 == c2);
  assign eq13 = (c1 == c3);
  assign eq23 = (c2 == c3);

  assign all_agree = eq12 & eq13;
  assign two_agree = (eq12 | eq13 | eq23) & ~all_agree;
  assign no_agree  = ~(eq12 | eq13 | eq23);

  // c1 wins whenever it is part of a majority; otherwise only c2==c3 remains.
  assign vote_word = (eq12 | eq13) ? c1 : c2;

endmodule

// File: rtl/aes_fault_ctrl.sv
// Sequencer for three lock-stepped AES engines: holds the inputs, votes the
// outputs, retries on total disagreement and locks with a sticky alarm.
module aes_fault_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int AES_LATENCY = 11,
  parameter int MAX_RETRY   = 2,
  parameter int FCNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_plaintext,
  input  logic [AES_BLOCK_W-1:0] in_key,
  output logic [AES_BLOCK_W-1:0] aes_pt,
  output logic [AES_BLOCK_W-1:0] aes_key,
  input  logic [AES_BLOCK_W-1:0] c1,
  input  logic [AES_BLOCK_W-1:0] c2,
  input  logic [AES_BLOCK_W-1:0] c3,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_ciphertext,
  output logic                   out_corrected,
  output logic                   alarm,
  input  logic                   alarm_clr,
  output logic [FCNT_W-1:0]      fault_count
);

  localparam int CNT_W   = (AES_LATENCY > 1) ? $clog2(AES_LATENCY) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(AES_LATENCY - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [RETRY_W-1:0]       retry;
  logic [FCNT_W-1:0]        fault_next;
  logic [AES_BLOCK_W-1:0]   vote_word;
  logic                     all_agree;
  logic                     two_agree;
  logic                     no_agree;

  aes_vote3 u_vote (
    .c1        (c1),
    .c2        (c2),
    .c3        (c3),
    .vote_word (vote_word),
    .all_agree (all_agree),
    .two_agree (two_agree),
    .no_agree  (no_agree)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign fault_next = (&fault_count) ? fault_count : fault_count + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      retry          <= '0;
      aes_pt         <= '0;
      aes_key        <= '0;
      out_ciphertext <= '0;
      out_corrected  <= 1'b0;
      alarm          <= 1'b0;
      fault_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            aes_pt  <= in_plaintext;
            aes_key <= in_key;
            cnt     <= '0;
            retry   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (cnt == CNT_LAST) begin
            state <= CHECK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          if (!no_agree) begin
            out_ciphertext <= vote_word;
            out_corrected  <= two_agree;
            if (two_agree) begin
              fault_count <= fault_next;
            end
            state <= OUT;
          end else if (retry < RETRY_MAX) begin
            // Re-run the same held block; the engines see no input change.
            retry       <= retry + 1'b1;
            fault_count <= fault_next;
            cnt         <= '0;
            state       <= RUN;
          end else begin
            fault_count <= fault_next;
            alarm       <= 1'b1;
            state       <= LOCK;
          end
        end
        OUT: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        LOCK: begin
          if (alarm_clr) begin
            alarm <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_all_agree;
  assign unused_all_agree = all_agree;

endmodule
